mac_inverse_div: RTL and testbench
==================================

MAC_INVERSE_DIV -- requirements
Module: mac_inverse_div

Interface
REQ-001 The block SHALL have parameter OPERATION, default 0, selecting the inverse of the multiply-accumulate post-adder: 0 = dividend is P - C (undoes ADD), 1 = dividend is P + C (undoes SUB).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin one division.
REQ-005 The block SHALL have port P, input, 48 bits, accumulated product to invert.
REQ-006 The block SHALL have port C, input, 48 bits, post-adder operand to remove.
REQ-007 The block SHALL have port A, input, 18 bits, multiplier operand used as divisor.
REQ-008 The block SHALL have port Q, output, 48 bits, registered quotient.
REQ-009 The block SHALL have port R, output, 18 bits, registered remainder.
REQ-010 The block SHALL have port busy, output, 1 bit, high while a division is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, single-cycle completion pulse.
REQ-012 The block SHALL have port div_zero, output, 1 bit, set when the captured A was 0.
REQ-013 The block SHALL have port wrap, output, 1 bit, set when the dividend computation overflowed or underflowed 48 bits.

Function
REQ-014 The block SHALL implement the states IDLE, PREP, DIV and DONE, with IDLE as the reset state.
REQ-015 In IDLE, start=1 on a rising edge SHALL capture P, C and A into internal registers, set busy=1 and move to PREP; input changes after that edge SHALL have no effect on the result.
REQ-016 In PREP, the block SHALL form the 48-bit dividend N = P - C (OPERATION=0) or P + C (OPERATION=1), modulo 2^48.
REQ-017 In PREP, wrap SHALL be set to the borrow out of P - C or the carry out of P + C.
REQ-018 In PREP, if A=0 the block SHALL set div_zero=1, load Q=48'hFFFF_FFFF_FFFF and R=N[17:0], and go directly to DONE.
REQ-019 In PREP, if A is nonzero the block SHALL go to DIV.
REQ-020 DIV SHALL perform an unsigned restoring division of N by A, one quotient bit per cycle, MSB first, for exactly 48 cycles, using a 19-bit partial remainder.
REQ-021 After the 48th DIV cycle, the block SHALL load Q and R and move to DONE, such that Q*A + R = N and R < A.
REQ-022 In DONE, the block SHALL drive done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-023 For a nonzero divisor, done SHALL rise 50 cycles after the start-sampling edge; for A=0, done SHALL rise 2 cycles after it.
REQ-024 Q, R, div_zero and wrap SHALL hold their values from DONE until the next start is accepted.
REQ-025 On acceptance of a new start, div_zero and wrap SHALL clear.
REQ-026 start SHALL be ignored whenever the state is not IDLE, with no effect on the running operation.
REQ-027 start held high continuously SHALL begin a new division on the first IDLE edge after each DONE.
REQ-028 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE and Q=0, R=0, busy=0, done=0, div_zero=0, wrap=0, and clear all internal registers, regardless of clock.
REQ-030 Reset asserted mid-division SHALL abort the operation with no done pulse.
REQ-031 After reset deasserts, the first start sampled in IDLE SHALL be accepted normally.

Verification
REQ-032 OPERATION=0, P=1000, C=100, A=9, start pulse -> busy high for 49 cycles, done 50 cycles after start, Q=100, R=0, wrap=0, div_zero=0.
REQ-033 OPERATION=0, P=5, C=10, A=7 -> wrap=1, N=2^48-5, Q=(2^48-5)/7, R=(2^48-5) mod 7, done at cycle 50.
REQ-034 A=0, P=300, C=0 -> div_zero=1, Q=48'hFFFF_FFFF_FFFF, R=300, done 2 cycles after start.
REQ-035 Start at cycle 0, second start pulse at cycle 10 with different operands -> second start ignored, single done at cycle 50 carrying the first operands' result.
REQ-036 Assert rst at cycle 20 of a division -> all outputs 0 immediately, no done pulse; new start with OPERATION=1, P=50, C=50, A=10 -> Q=10, R=0.

Source files
------------

// File: rtl/mac_inverse_div.sv
// Inverts a multiply-accumulate result: removes the post-adder operand C from P,
// then divides by the multiplier operand A using a 48-step restoring divider.
module mac_inverse_div #(
  parameter int OPERATION = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] P,
  input  logic [47:0] C,
  input  logic [17:0] A,
  output logic [47:0] Q,
  output logic [17:0] R,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic        wrap
);

  typedef enum logic [1:0] {IDLE, PREP, DIV, DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [47:0] r_p;
  logic [47:0] r_c;
  logic [17:0] r_a;
  logic [47:0] r_quo;
  logic [18:0] r_rem;
  logic [5:0]  r_cnt;
  logic [47:0] r_q;
  logic [17:0] r_r;
  logic        r_busy;
  logic        r_done;
  logic        r_dz;
  logic        r_wrap;

  logic [48:0] w_sum;
  logic [48:0] w_diff;
  logic [48:0] w_dividend;
  logic [18:0] w_shift;
  logic [18:0] w_sub;
  logic        w_ge;
  logic [18:0] w_remNext;
  logic [47:0] w_quoNext;

  // Bit 48 carries the borrow of P - C or the carry of P + C.
  assign w_sum      = {1'b0, r_p} + {1'b0, r_c};
  assign w_diff     = {1'b0, r_p} - {1'b0, r_c};
  assign w_dividend = (OPERATION != 0) ? w_sum : w_diff;

  // r_quo starts as the dividend and shifts quotient bits in from the right.
  assign w_shift   = {r_rem[17:0], r_quo[47]};
  assign w_ge      = (w_shift >= {1'b0, r_a});
  assign w_sub     = w_shift - {1'b0, r_a};
  assign w_remNext = w_ge ? w_sub : w_shift;
  assign w_quoNext = {r_quo[46:0], w_ge};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = PREP;
      PREP:    w_next = (r_a == 18'd0) ? DONE : DIV;
      DIV:     if (r_cnt == 6'd47) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p    <= '0;
      r_c    <= '0;
      r_a    <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_cnt  <= '0;
      r_q    <= '0;
      r_r    <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_wrap <= 1'b0;
    end else begin
      // The done pulse lands on the edge that leaves DONE.
      r_done <= (r_state == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_p    <= P;
            r_c    <= C;
            r_a    <= A;
            r_busy <= 1'b1;
            r_dz   <= 1'b0;
            r_wrap <= 1'b0;
          end
        end
        PREP: begin
          r_wrap <= w_dividend[48];
          r_quo  <= w_dividend[47:0];
          r_rem  <= '0;
          r_cnt  <= '0;
          if (r_a == 18'd0) begin
            r_dz   <= 1'b1;
            r_q    <= 48'hFFFF_FFFF_FFFF;
            r_r    <= w_dividend[17:0];
            r_busy <= 1'b0;
          end
        end
        DIV: begin
          r_rem <= w_remNext;
          r_quo <= w_quoNext;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd47) begin
            r_q    <= w_quoNext;
            r_r    <= w_remNext[17:0];
            r_busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign Q        = r_q;
  assign R        = r_r;
  assign busy     = r_busy;
  assign done     = r_done;
  assign div_zero = r_dz;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_mac_inverse_div.sv
// Directed self-checking bench for mac_inverse_div; one instance per OPERATION value
// shares clock, reset and operand buses.
module tb_mac_inverse_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [47:0] P, C;
  logic [17:0] A;

  logic [47:0] q0, q1;
  logic [17:0] r0, r1;
  logic        busy0, busy1, done0, done1, dz0, dz1, wrap0, wrap1;

  logic        sel;
  logic [47:0] sQ;
  logic [17:0] sR;
  logic        sBusy, sDone, sDz, sWrap;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_inverse_div #(.OPERATION(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .P(P), .C(C), .A(A),
    .Q(q0), .R(r0), .busy(busy0), .done(done0), .div_zero(dz0), .wrap(wrap0)
  );

  mac_inverse_div #(.OPERATION(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .P(P), .C(C), .A(A),
    .Q(q1), .R(r1), .busy(busy1), .done(done1), .div_zero(dz1), .wrap(wrap1)
  );

  assign sQ    = sel ? q1    : q0;
  assign sR    = sel ? r1    : r0;
  assign sBusy = sel ? busy1 : busy0;
  assign sDone = sel ? done1 : done0;
  assign sDz   = sel ? dz1   : dz0;
  assign sWrap = sel ? wrap1 : wrap0;

  typedef struct {
    logic        op;
    logic [47:0] p;
    logic [47:0] c;
    logic [17:0] a;
    logic [47:0] q;
    logic [17:0] r;
    logic        wrap;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle, scrambles operands right after capture, then waits for done.
  task automatic applyStimulus(input vec_t v, input string tag);
    int cyc;
    int busyCnt;
    bit seen;
    @(negedge clk);
    sel = v.op;
    P = v.p; C = v.c; A = v.a;
    if (v.op) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    P = 48'h5A5A_A5A5_1234; C = 48'h0F0F_F0F0_4321; A = 18'h155;
    busyCnt = sBusy ? 1 : 0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 60) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (sDone) seen = 1'b1;
      else if (sBusy) busyCnt++;
    end
    checkOutput({tag, "_done_seen"}, 64'(seen), 64'd1);
    checkOutput({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    checkOutput({tag, "_busy_cycles"}, 64'(busyCnt), 64'(v.lat - 1));
    checkOutput({tag, "_Q"}, 64'(sQ), 64'(v.q));
    checkOutput({tag, "_R"}, 64'(sR), 64'(v.r));
    checkOutput({tag, "_wrap"}, 64'(sWrap), 64'(v.wrap));
    checkOutput({tag, "_div_zero"}, 64'(sDz), 64'(v.dz));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_done_single"}, 64'(sDone), 64'd0);
    checkOutput({tag, "_Q_hold"}, 64'(sQ), 64'(v.q));
  endtask

  initial begin
    int cyc;
    int doneCnt;
    int firstDone;
    int d1;
    int d2;
    logic busyAfter;
    vec_t v;

    vecs[0] = '{1'b0, 48'd1000, 48'd100, 18'd9, 48'd100, 18'd0, 1'b0, 1'b0, 50};
    vecs[1] = '{1'b0, 48'd5, 48'd10, 18'd7, 48'd40210710958664, 18'd3, 1'b1, 1'b0, 50};
    vecs[2] = '{1'b0, 48'd300, 48'd0, 18'd0, 48'hFFFF_FFFF_FFFF, 18'd300, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b0, 48'hFFFF_FFFF_FFFF, 48'd0, 18'h3FFFF, 48'd1073745920, 18'd4095, 1'b0, 1'b0, 50};
    vecs[4] = '{1'b0, 48'd123456, 48'd0, 18'd1, 48'd123456, 18'd0, 1'b0, 1'b0, 50};
    vecs[5] = '{1'b0, 48'd10, 48'd0, 18'd20, 48'd0, 18'd10, 1'b0, 1'b0, 50};
    vecs[6] = '{1'b1, 48'hFFFF_FFFF_FFFF, 48'd2, 18'd3, 48'd0, 18'd1, 1'b1, 1'b0, 50};
    vecs[7] = '{1'b0, 48'd0, 48'd1, 18'd0, 48'hFFFF_FFFF_FFFF, 18'h3FFFF, 1'b1, 1'b1, 2};
    vecs[8] = '{1'b1, 48'd1000, 48'd23, 18'd17, 48'd60, 18'd3, 1'b0, 1'b0, 50};
    vecs[9] = '{1'b1, 48'd50, 48'd50, 18'd10, 48'd10, 18'd0, 1'b0, 1'b0, 50};

    sel = 1'b0; start0 = 1'b0; start1 = 1'b0;
    P = '0; C = '0; A = '0;
    rst = 1'b1;
    #12;
    checkOutput("reset_Q0", 64'(q0), 64'd0);
    checkOutput("reset_R0", 64'(r0), 64'd0);
    checkOutput("reset_flags0", 64'({busy0, done0, dz0, wrap0}), 64'd0);
    checkOutput("reset_flags1", 64'({busy1, done1, dz1, wrap1, q1 == 48'd0, r1 == 18'd0}), 64'b000011);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // A second start mid-division must be ignored.
    @(negedge clk);
    sel = 1'b0; P = 48'd1000; C = 48'd100; A = 18'd9; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    cyc = 0; doneCnt = 0; firstDone = -1;
    for (int i = 0; i < 55; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done0) begin
        doneCnt++;
        if (firstDone < 0) firstDone = cyc;
      end
      if (cyc == 9) begin
        P = 48'd7; C = 48'd0; A = 18'd2; start0 = 1'b1;
      end else if (cyc == 10) begin
        start0 = 1'b0;
      end
    end
    checkOutput("ignore_done_count", 64'(doneCnt), 64'd1);
    checkOutput("ignore_done_cycle", 64'(firstDone), 64'd50);
    checkOutput("ignore_Q", 64'(q0), 64'd100);
    checkOutput("ignore_R", 64'(r0), 64'd0);

    // Start held high restarts on the first IDLE edge after each done.
    @(negedge clk);
    P = 48'd300; C = 48'd0; A = 18'd0; start0 = 1'b1;
    @(posedge clk);
    cyc = 0; d1 = -1; d2 = -1; busyAfter = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (done0) begin
        if (d1 < 0) d1 = cyc;
        else if (d2 < 0) d2 = cyc;
      end
      if (cyc == 3) busyAfter = busy0;
    end
    start0 = 1'b0;
    checkOutput("hold_first_done", 64'(d1), 64'd2);
    checkOutput("hold_busy_restart", 64'(busyAfter), 64'd1);
    checkOutput("hold_second_done", 64'(d2), 64'd5);
    repeat (10) @(negedge clk);

    // Reset mid-division aborts without a done pulse.
    P = 48'd1000; C = 48'd100; A = 18'd9; start0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_Q", 64'(q0), 64'd0);
    checkOutput("abort_R", 64'(r0), 64'd0);
    checkOutput("abort_flags", 64'({busy0, done0, dz0, wrap0}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done0) doneCnt++;
    end
    checkOutput("abort_no_done", 64'(doneCnt), 64'd0);

    v = vecs[9];
    applyStimulus(v, "after_reset_op1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
